// File: rtl/olo_intf_led_pkg.sv
// olo_intf_led_pkg: shared FSM state type and time-to-cycles helper for the LED player
package olo_intf_led_pkg;
  typedef enum logic [1:0] {Idle, Show, Gap} state_t;
  // Ceiling of freq*t, tolerant of floating-point noise just above an integer
  function automatic int cycles(real freq, real t);
    real x;
    int c;
    x = freq * t;
    c = $rtoi(x);
    if (x - real'(c) > 1.0e-6) c = c + 1;
    return c;
  endfunction
endpackage

// File: rtl/olo_intf_led_player.sv
// olo_intf_led_player: pops stream words and shows each on LEDs for a hold time, then blanks for a gap
module olo_intf_led_player
  import olo_intf_led_pkg::*;
#(
  parameter real ClkFrequency_g = 125.0e6,
  parameter real HoldTime_g     = 0.5,
  parameter real GapTime_g      = 0.1,
  parameter int  Width_g        = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [Width_g-1:0] in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               clear_i,
  output logic [Width_g-1:0] led_o,
  output logic               out_strobe_o,
  output logic               busy_o
);
  localparam int HoldRaw    = cycles(ClkFrequency_g, HoldTime_g);
  localparam int HoldCycles = HoldRaw < 1 ? 1 : HoldRaw;
  localparam int GapCycles  = cycles(ClkFrequency_g, GapTime_g);
  localparam int CntMax     = HoldCycles > GapCycles ? (HoldCycles > 2 ? HoldCycles : 2)
                                                     : (GapCycles > 2 ? GapCycles : 2);
  localparam int CntW       = $clog2(CntMax);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLoad  = GapCycles > 0 ? CntW'(GapCycles - 1) : '0;
  if (!(HoldTime_g > 0.0) || !(GapTime_g >= 0.0) || !(ClkFrequency_g > 0.0)) begin : g_bad_param
    $error("olo_intf_led_player: HoldTime_g>0, GapTime_g>=0 and ClkFrequency_g>0 required");
  end
  state_t              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [Width_g-1:0]  data_q, data_d, led_q, led_d;
  logic                strobe_q, strobe_d;
  assign in_ready_o   = (state_q == Idle) && !clear_i && rst_n_i;
  assign busy_o       = state_q != Idle;
  assign led_o        = led_q;
  assign out_strobe_o = strobe_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    case (state_q)
      Idle: if (in_valid_i && in_ready_o) begin
        state_d  = Show;
        cnt_d    = HoldLoad;
        data_d   = in_data_i;
        strobe_d = 1'b1;
      end
      Show: begin
        state_d = cnt_q == '0 ? (GapCycles > 0 ? Gap : Idle) : Show;
        cnt_d   = cnt_q == '0 ? GapLoad : cnt_q - CntW'(1);
      end
      Gap: begin
        state_d = cnt_q == '0 ? Idle : Gap;
        cnt_d   = cnt_q == '0 ? '0 : cnt_q - CntW'(1);
      end
      default: state_d = Idle;
    endcase
    if (clear_i) begin
      state_d  = Idle;
      cnt_d    = '0;
      strobe_d = 1'b0;
    end
    led_d = state_d == Show ? data_d : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= Idle;
      cnt_q    <= '0;
      data_q   <= '0;
      led_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      led_q    <= led_d;
      strobe_q <= strobe_d;
    end
  end
endmodule

// File: tb/tb_olo_intf_led_player.sv
// tb_olo_intf_led_player: table vectors, hand sequences and a strobe scoreboard for the LED player
module tb_olo_intf_led_player;
  import olo_intf_led_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_data = '0, data_b = '0;
  logic       in_valid = 1'b0, valid_b = 1'b0;
  logic       clear = 1'b0, clear_b = 1'b0;
  logic       in_ready, strobe, busy, ready_b, strobe_b, busy_b;
  logic [3:0] led, led_b;
  int         n_cmp = 0, n_err = 0, cyc = 0;
  logic [3:0] sb_q[$];

  olo_intf_led_player #(.ClkFrequency_g(1.0e6), .HoldTime_g(10.0e-6), .GapTime_g(3.0e-6), .Width_g(4)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .clear_i(clear), .led_o(led), .out_strobe_o(strobe), .busy_o(busy));

  olo_intf_led_player #(.ClkFrequency_g(1.0e6), .HoldTime_g(10.0e-6), .GapTime_g(0.0), .Width_g(4)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .in_data_i(data_b), .in_valid_i(valid_b), .in_ready_o(ready_b),
    .clear_i(clear_b), .led_o(led_b), .out_strobe_o(strobe_b), .busy_o(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 40 && !in_ready; i++) tick();
    chk(name, int'(in_ready), 1);
  endtask

  // Scoreboard: accepted words pushed at handshake, popped at each strobe
  always @(negedge clk) begin
    if (rst_n && strobe) begin
      if (sb_q.size() == 0) chk("sb_unexpected_strobe", 1, 0);
      else chk("sb_led_at_strobe", int'(led), int'(sb_q.pop_front()));
    end
    if (in_valid && in_ready) sb_q.push_back(in_data);
  end

  typedef struct {
    logic       valid;
    logic [3:0] data;
    logic       ready;
    logic       strobe;
    logic       busy;
    logic [3:0] led;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int t[4];
    int acc[$];
    int zeros;
    tbl[0] = '{1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0};
    for (int k = 1; k <= 10; k++) tbl[k] = '{1'b0, 4'h0, 1'b0, k == 1, 1'b1, 4'hA};
    for (int k = 11; k <= 13; k++) tbl[k] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
    tbl[14] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
    chk("cycles_hold", cycles(1.0e6, 10.0e-6), 10);
    chk("cycles_gap", cycles(1.0e6, 3.0e-6), 3);
    repeat (3) tick();
    in_valid = 1'b1;
    in_data = 4'hF;
    #1;
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobe", int'(strobe), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", int'(in_ready), 1);
    for (int r = 0; r < 15; r++) begin
      in_valid = tbl[r].valid;
      in_data = tbl[r].data;
      #1;
      chk($sformatf("tbl%0d_ready", r), int'(in_ready), int'(tbl[r].ready));
      chk($sformatf("tbl%0d_strobe", r), int'(strobe), int'(tbl[r].strobe));
      chk($sformatf("tbl%0d_busy", r), int'(busy), int'(tbl[r].busy));
      chk($sformatf("tbl%0d_led", r), int'(led), int'(tbl[r].led));
      tick();
    end
    // Back-to-back with valid held
    in_valid = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      in_data = 4'(w);
      #1;
      for (int i = 0; i < 40 && !in_ready; i++) tick();
      chk($sformatf("b2b_accept%0d", w), int'(in_ready), 1);
      t[w] = cyc;
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_period12", t[2] - t[1], 14);
    chk("b2b_period23", t[3] - t[2], 14);
    wait_ready("b2b_idle");
    // Clear mid-Show
    in_data = 4'h5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    clear = 1'b1;
    #1;
    chk("clr_show_ready_low", int'(in_ready), 0);
    tick();
    clear = 1'b0;
    #1;
    chk("clr_show_led", int'(led), 0);
    chk("clr_show_busy", int'(busy), 0);
    chk("clr_show_ready", int'(in_ready), 1);
    in_data = 4'h6;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("clr_next_led", int'(led), 6);
    chk("clr_next_strobe", int'(strobe), 1);
    wait_ready("clr_next_idle");
    // Clear with valid in Idle
    in_data = 4'h7;
    in_valid = 1'b1;
    clear = 1'b1;
    #1;
    chk("clr_idle_ready", int'(in_ready), 0);
    tick();
    chk("clr_idle_busy", int'(busy), 0);
    chk("clr_idle_led", int'(led), 0);
    clear = 1'b0;
    #1;
    chk("clr_idle_ready_after", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("clr_idle_led_after", int'(led), 7);
    chk("clr_idle_strobe_after", int'(strobe), 1);
    wait_ready("clr_idle_done");
    // Reset mid-Gap
    in_data = 4'h9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    chk("rgap_led_gap", int'(led), 0);
    chk("rgap_busy_gap", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rgap_ready_in_rst", int'(in_ready), 0);
    tick();
    chk("rgap_led", int'(led), 0);
    chk("rgap_busy", int'(busy), 0);
    chk("rgap_strobe", int'(strobe), 0);
    rst_n = 1'b1;
    #1;
    chk("rgap_ready_release", int'(in_ready), 1);
    // Clear and reset together mid-Show
    in_data = 4'h3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    clear = 1'b1;
    tick();
    chk("rclr_led", int'(led), 0);
    chk("rclr_busy", int'(busy), 0);
    chk("rclr_strobe", int'(strobe), 0);
    rst_n = 1'b1;
    clear = 1'b0;
    #1;
    chk("rclr_ready", int'(in_ready), 1);
    // Zero-gap variant
    data_b = 4'hC;
    valid_b = 1'b1;
    #1;
    for (int i = 0; i < 40 && !ready_b; i++) tick();
    chk("g0_first_ready", int'(ready_b), 1);
    zeros = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (ready_b) acc.push_back(i);
      if (led_b == 4'h0) zeros++;
      if (strobe_b) chk("g0_strobe_led", int'(led_b), 12);
    end
    valid_b = 1'b0;
    chk("g0_accepts", acc.size(), 2);
    if (acc.size() == 2) begin
      chk("g0_accept_a", acc[0], 10);
      chk("g0_accept_b", acc[1], 21);
    end
    chk("g0_blank_cycles", zeros, 2);
    repeat (15) tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
